addsub_seq: RTL and testbench
=============================

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, two's complement.
REQ-002 SHALL have parameter DIGIT, default 2: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port m  input  1  mode: 0 = a+b, 1 = a-b.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port s  output  WIDTH  result.
REQ-012 SHALL have port v  output  1  signed overflow.
REQ-013 SHALL have port c  output  1  carry out of MSB (for subtract, 1 = no borrow).

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be registered-state decodes.
REQ-016 Accept occurs on an edge with in_valid&&in_ready; at accept SHALL latch a, b XOR {WIDTH{m}}, and carry-in = m, then enter BUSY.
REQ-017 Operand input changes after the accept edge SHALL NOT affect the result.
REQ-018 BUSY SHALL last exactly N cycles, each cycle adding one DIGIT-bit slice, LSB slice first, rippling the carry into a carry register.
REQ-019 After the Nth BUSY cycle SHALL enter DONE; out_valid rises N edges after the accept edge.
REQ-020 On entry to DONE, s, v and c SHALL update: v = carry into MSB XOR carry out of MSB; c = carry out of MSB.
REQ-021 s, v and c SHALL change only on entry to DONE and SHALL hold the last result at all other times, including IDLE and BUSY.
REQ-022 DONE SHALL persist with s, v and c stable until an edge with out_ready=1, then go to IDLE.
REQ-023 If out_ready is already high, out_valid SHALL be high for exactly one cycle.
REQ-024 in_valid during BUSY/DONE SHALL be ignored (no queuing).
REQ-025 With in_valid and out_ready held high, SHALL start a new operation every N+2 cycles.
REQ-026 Without saturation, s SHALL be the wrap-around WIDTH-bit sum modulo 2^WIDTH.

Reset
REQ-027 rst_n low SHALL immediately force state = IDLE, s = 0, v = 0, c = 0, internal carry and slice counter = 0, independent of clk.
REQ-028 Reset during BUSY or DONE SHALL discard the operation with no out_valid pulse; after release, in_ready = 1.

Configuration
REQ-029 Macro ADDSUB_SAT_EN, when defined, SHALL compile in saturation: if v = 1, s = 0111..1 when latched a[MSB] = 0, else 1000..0; v and c are unchanged.
REQ-030 When ADDSUB_SAT_EN is undefined, s SHALL be the wrap-around result per REQ-026, with no saturation logic present.

Verification (WIDTH=4, DIGIT=1 unless stated)
REQ-031 m=0, a=-8, b=-8 -> s=0000, v=1, c=1; with ADDSUB_SAT_EN, s=1000.
REQ-032 m=0, a=7, b=7 -> s=1110, v=1, c=0; with ADDSUB_SAT_EN, s=0111.
REQ-033 m=1, a=-4, b=3 -> s=1001, v=0, c=1; m=1, a=0, b=-4 -> s=0100, v=0, c=0.
REQ-034 WIDTH=8, DIGIT=2, m=0, a=0x7F, b=0x01, out_ready=1 -> out_valid 4 edges after accept, one cycle wide, s=0x80, v=1, c=0.
REQ-035 out_ready held 0 for 3 cycles in DONE -> out_valid, s, v, c stable and in_ready=0 throughout; a new in_valid is ignored; IDLE is entered on the first edge with out_ready=1.
REQ-036 rst_n pulsed low mid-BUSY -> in_ready=1, out_valid=0 and s=v=c=0 immediately; no result is emitted for the aborted operation.

Source files
------------

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seq
// Brief    : Digit-serial two's-complement adder/subtractor, DIGIT bits per
//            cycle, valid/ready handshake on both sides. Optional macro
//            ADDSUB_SAT_EN saturates the result on signed overflow.
// Revision : 1.0  initial release
// ============================================================================

module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             v,
  output logic             c
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
      $error("addsub_seq: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic [DIGIT-1:0] sl_a;
  logic [DIGIT-1:0] sl_b;
  logic [DIGIT-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             ovf;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] res_final;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;
  assign last      = (state == BUSY) && (cnt == LAST_SLICE);

  // Operands shift right each cycle, so the active slice is always the bottom one.
  assign sl_a = opa[DIGIT-1:0];
  assign sl_b = opb[DIGIT-1:0];
  assign {sl_cout, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + (DIGIT+1)'(carry);

  // On the final slice the top bit of the slice is the word MSB.
  assign sl_cmsb = sl_a[DIGIT-1] ^ sl_b[DIGIT-1] ^ sl_sum[DIGIT-1];
  assign ovf     = sl_cmsb ^ sl_cout;

  // Sum bits enter at the top and move down, landing in place after N cycles.
  assign acc_nx = (acc >> DIGIT) | (WIDTH'(sl_sum) << (WIDTH - DIGIT));

`ifdef ADDSUB_SAT_EN
  logic             a_msb;
  logic [WIDTH-1:0] sat_val;

  assign sat_val   = {a_msb, {(WIDTH-1){~a_msb}}};
  assign res_final = ovf ? sat_val : acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
    end
  end
`else
  assign res_final = acc_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      v     <= 1'b0;
      c     <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b ^ {WIDTH{m}};
      carry <= m;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == BUSY) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      carry <= sl_cout;
      acc   <= acc_nx;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        s <= res_final;
        v <= ovf;
        c <= sl_cout;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_seq
// Brief    : Self-checking bench for addsub_seq (4/1 and 8/2 instances)
//            against a signed-integer arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================

module tb_addsub_seq;

  localparam int NSL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv4, ir4, m4, ov4, or4, v4, c4;
  logic [3:0] a4, b4, s4;
  logic       iv8, ir8, m8, ov8, or8, v8, c8;
  logic [7:0] a8, b8, s8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] prev_s [2];
  logic       prev_v [2];
  logic       prev_c [2];

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(4), .DIGIT(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .m(m4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .s(s4), .v(v4), .c(c4)
  );

  addsub_seq #(.WIDTH(8), .DIGIT(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .m(m8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .s(s8), .v(v8), .c(c8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_s(input int w);
    return (w == 0) ? 32'(s4) : 32'(s8);
  endfunction
  function automatic logic [31:0] g_v(input int w);
    return (w == 0) ? 32'(v4) : 32'(v8);
  endfunction
  function automatic logic [31:0] g_c(input int w);
    return (w == 0) ? 32'(c4) : 32'(c8);
  endfunction
  function automatic logic [31:0] g_ir(input int w);
    return (w == 0) ? 32'(ir4) : 32'(ir8);
  endfunction
  function automatic logic [31:0] g_ov(input int w);
    return (w == 0) ? 32'(ov4) : 32'(ov8);
  endfunction

  task automatic drive(input int w, input logic vld, input logic md,
                       input logic [7:0] a, input logic [7:0] b);
    if (w == 0) begin
      iv4 = vld; m4 = md; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      iv8 = vld; m8 = md; a8 = a; b8 = b;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 0) or4 = r;
    else        or8 = r;
  endtask

  // Reference: plain signed/unsigned integer arithmetic at the given width.
  function automatic void model(input int wb, input logic md,
                                input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] es, output logic ev,
                                output logic ec);
    int mask, au, bu, as_, bs_, r;
    mask = (1 << wb) - 1;
    au   = int'(a) & mask;
    bu   = int'(b) & mask;
    as_  = (au >= (1 << (wb-1))) ? au - (1 << wb) : au;
    bs_  = (bu >= (1 << (wb-1))) ? bu - (1 << wb) : bu;
    r    = md ? as_ - bs_ : as_ + bs_;
    ev   = (r > (1 << (wb-1)) - 1) || (r < -(1 << (wb-1)));
    es   = 8'(r & mask);
    ec   = md ? (au >= bu) : ((au + bu) >= (1 << wb));
`ifdef ADDSUB_SAT_EN
    if (ev) es = (as_ >= 0) ? 8'(mask >> 1) : 8'(1 << (wb-1));
`endif
  endfunction

  // rdly < 0: out_ready is already high before the result appears.
  task automatic run_op(input int w, input logic md, input logic [7:0] a,
                        input logic [7:0] b, input int rdly);
    logic [7:0] es;
    logic       ev, ec;
    int         k, lat;
    model((w == 0) ? 4 : 8, md, a, b, es, ev, ec);
    k = 0;
    while (g_ir(w) !== 32'd1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_wait", g_ir(w), 32'd1);
    drive(w, 1'b1, md, a, b);
    if (rdly < 0) set_ordy(w, 1'b1);
    @(posedge clk); #1;
    lat = 0;
    while (g_ov(w) !== 32'd1 && lat < 20) begin
      chk("busy_in_ready", g_ir(w), 32'd0);
      chk("busy_s_held", g_s(w), 32'(prev_s[w]));
      chk("busy_v_held", g_v(w), 32'(prev_v[w]));
      chk("busy_c_held", g_c(w), 32'(prev_c[w]));
      drive(w, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(NSL));
    chk("done_s", g_s(w), 32'(es));
    chk("done_v", g_v(w), 32'(ev));
    chk("done_c", g_c(w), 32'(ec));
    chk("done_in_ready", g_ir(w), 32'd0);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", g_ov(w), 32'd1);
      chk("hold_in_ready", g_ir(w), 32'd0);
      chk("hold_s", g_s(w), 32'(es));
      chk("hold_v", g_v(w), 32'(ev));
      chk("hold_c", g_c(w), 32'(ec));
    end
    drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    chk("release_out_valid", g_ov(w), 32'd0);
    chk("release_in_ready", g_ir(w), 32'd1);
    chk("idle_s_held", g_s(w), 32'(es));
    set_ordy(w, 1'b0);
    prev_s[w] = es;
    prev_v[w] = ev;
    prev_c[w] = ec;
  endtask

  initial begin
    logic [7:0] es;
    logic       ev, ec;
    int         last_cyc, pulses, k;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0);
    or4 = 1'b0;
    or8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prev_s[i] = 8'd0; prev_v[i] = 1'b0; prev_c[i] = 1'b0;
    end
    #3;
    for (int w = 0; w < 2; w++) begin
      chk("rst_in_ready", g_ir(w), 32'd1);
      chk("rst_out_valid", g_ov(w), 32'd0);
      chk("rst_s", g_s(w), 32'd0);
      chk("rst_v", g_v(w), 32'd0);
      chk("rst_c", g_c(w), 32'd0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases on the 4-bit, 1-bit-per-cycle instance.
    run_op(0, 1'b0, 8'h08, 8'h08, 0);
    run_op(0, 1'b0, 8'h07, 8'h07, 2);
    run_op(0, 1'b1, 8'h0C, 8'h03, -1);
    run_op(0, 1'b1, 8'h00, 8'h0C, 3);

    // 8-bit, 2-bit-per-cycle overflow case with out_ready already high.
    run_op(1, 1'b0, 8'h7F, 8'h01, -1);

    for (int i = 0; i < 16; i++) begin
      run_op(i % 2, 1'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 4)) - 1);
    end

    // Back-to-back throughput with both handshakes held high.
    model(4, 1'b0, 8'h03, 8'h02, es, ev, ec);
    drive(0, 1'b1, 1'b0, 8'h03, 8'h02);
    set_ordy(0, 1'b1);
    last_cyc = -1;
    pulses   = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (ov4 === 1'b1) begin
        chk("thru_s", g_s(0), 32'(es));
        if (last_cyc >= 0) chk("thru_period", 32'(cyc - last_cyc), 32'(NSL + 2));
        last_cyc = cyc;
        pulses++;
      end
    end
    chk("thru_pulses", 32'(pulses >= 4), 32'd1);
    drive(0, 1'b0, 1'b0, 8'h03, 8'h02);
    k = 0;
    while (!(ir4 === 1'b1 && ov4 === 1'b0) && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("thru_drain", g_ir(0), 32'd1);
    set_ordy(0, 1'b0);
    prev_s[0] = es; prev_v[0] = ev; prev_c[0] = ec;

    // Abort mid-BUSY with an asynchronous reset.
    drive(1, 1'b1, 1'b0, 8'h7F, 8'h01);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("abort_in_ready", g_ir(w), 32'd1);
      chk("abort_out_valid", g_ov(w), 32'd0);
      chk("abort_s", g_s(w), 32'd0);
      chk("abort_v", g_v(w), 32'd0);
      chk("abort_c", g_c(w), 32'd0);
      prev_s[w] = 8'd0; prev_v[w] = 1'b0; prev_c[w] = 1'b0;
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < NSL + 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", g_ov(1), 32'd0);
    end
    run_op(1, 1'b1, 8'h80, 8'h01, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
